// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, NOP encoding and queue-entry type for fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO with flush; head word is read combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !rst) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      assert (!(push_i && full_o && !pop_i));
      assert (!(pop_i && empty_o));
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : PC, imem request handshake and redirect control over a queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               decode_ready
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ENTRY_W-1:0] head_w;
  logic [CNT_W-1:0]   q_count_w;
  logic               q_full_w, q_empty_w;
  logic               pop_w, fire_w;

  assign ir_valid = !q_empty_w;
  assign pop_w    = ir_valid && decode_ready && !redirect;
  // A same-cycle pop frees a slot, so decode_ready feeds imem_req directly.
  assign imem_req = !rst && !redirect && (!q_full_w || (ir_valid && decode_ready));
  assign fire_w   = imem_req && imem_ready;

  always_comb begin
    pc_d = pc_q;
    if (redirect)    pc_d = redirect_pc;
    else if (fire_w) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= ADDR_W'(RESET_PC);
    else     pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (q_count_w <= CNT_W'(DEPTH));
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fire_w),
    .pop_i   (pop_w),
    .flush_i (redirect),
    .wdata_i ({pc_q, imem_data}),
    .rdata_o (head_w),
    .full_o  (q_full_w),
    .empty_o (q_empty_w),
    .count_o (q_count_w)
  );

  assign imem_addr = pc_q;
  assign ir_out    = ir_valid ? head_w[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);
  assign ir_pc     = ir_valid ? head_w[ENTRY_W-1:INSTR_W] : '0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
// ============================================================================
// Module      : tb_fetch_prefetch_unit
// Description : Directed and random stimulus against a queue-based fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ready, redirect, ir_valid, decode_ready;
  logic [7:0]  imem_addr, redirect_pc, ir_pc;
  logic [15:0] imem_data, ir_out;

  int n_err = 0;
  int n_chk = 0;

  fetch_entry_t mq[$];
  logic [7:0]   mpc;

  always #5 clk = ~clk;

  assign imem_data = {imem_addr, ~imem_addr};

  fetch_prefetch_unit #(
    .ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_data    (imem_data),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ir_valid     (ir_valid),
    .ir_out       (ir_out),
    .ir_pc        (ir_pc),
    .decode_ready (decode_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs to the model mid-cycle, then advance the model.
  task automatic step();
    logic        e_valid, e_req;
    logic [15:0] e_out;
    logic [7:0]  e_pc;
    @(negedge clk);
    e_valid = (mq.size() != 0);
    e_out   = e_valid ? mq[0].instr : 16'h0000;
    e_pc    = e_valid ? mq[0].pc : 8'h00;
    e_req   = !rst && !redirect && ((mq.size() < DEPTH) || (e_valid && decode_ready));
    chk("ir_valid",  {31'd0, ir_valid}, {31'd0, e_valid});
    chk("ir_out",    {16'd0, ir_out},   {16'd0, e_out});
    chk("ir_pc",     {24'd0, ir_pc},    {24'd0, e_pc});
    chk("imem_req",  {31'd0, imem_req}, {31'd0, e_req});
    chk("imem_addr", {24'd0, imem_addr}, {24'd0, mpc});
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mpc = 8'h00;
    end else if (redirect) begin
      mq.delete();
      mpc = redirect_pc;
    end else begin
      if (e_valid && decode_ready) void'(mq.pop_front());
      if (e_req && imem_ready) begin
        mq.push_back('{pc: mpc, instr: {mpc, ~mpc}});
        mpc = mpc + 8'd1;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;
    decode_ready = 1'b0; imem_ready = 1'b1;

    // Reset: first edge initialises the DUT, second is checked.
    @(posedge clk);
    mq.delete(); mpc = 8'h00;
    #1;
    step();
    rst = 1'b0; decode_ready = 1'b1;
    #1;
    chk("rst_addr",  {24'd0, imem_addr}, 32'h00);
    chk("rst_valid", {31'd0, ir_valid},  32'h0);
    chk("rst_irout", {16'd0, ir_out},    32'h0);
    step();
    chk("first_ir",  {16'd0, ir_out}, 32'h00FF);
    chk("first_pc",  {24'd0, ir_pc},  32'h00);

    // Streaming with PC wrap.
    for (int i = 0; i < 300; i++) step();

    // Stall until full from 0x10, then release.
    redirect = 1'b1; redirect_pc = 8'h10;
    step();
    redirect = 1'b0; decode_ready = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("full_req",  {31'd0, imem_req},  32'h0);
    chk("full_addr", {24'd0, imem_addr}, 32'h14);
    chk("full_head", {16'd0, ir_out},    32'h10EF);
    decode_ready = 1'b1;
    #1;
    chk("release_req", {31'd0, imem_req}, 32'h1);
    for (int i = 0; i < 6; i++) step();

    // Redirect with three queued entries.
    redirect = 1'b1; redirect_pc = 8'h20;
    step();
    redirect = 1'b0; decode_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    redirect = 1'b1; redirect_pc = 8'h80; decode_ready = 1'b1;
    step();
    redirect = 1'b0;
    #1;
    chk("redir_valid", {31'd0, ir_valid},  32'h0);
    chk("redir_addr",  {24'd0, imem_addr}, 32'h80);
    step();
    chk("redir_ir", {16'd0, ir_out}, 32'h807F);
    chk("redir_pc", {24'd0, ir_pc},  32'h80);

    // Memory stall with two queued entries.
    decode_ready = 1'b0;
    step();
    imem_ready = 1'b0; decode_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("mstall_valid", {31'd0, ir_valid},  32'h0);
    chk("mstall_addr",  {24'd0, imem_addr}, 32'h82);
    imem_ready = 1'b1;
    step();
    chk("mstall_ir", {16'd0, ir_out}, 32'h827D);
    chk("mstall_pc", {24'd0, ir_pc},  32'h82);

    // Reset wins over a simultaneous redirect.
    rst = 1'b1; redirect = 1'b1; redirect_pc = 8'h40;
    step();
    rst = 1'b0; redirect = 1'b0;
    #1;
    chk("rstredir_addr",  {24'd0, imem_addr}, 32'h00);
    chk("rstredir_valid", {31'd0, ir_valid},  32'h0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      redirect     = ($urandom_range(0, 19) == 0);
      redirect_pc  = 8'($urandom);
      decode_ready = ($urandom_range(0, 3) != 0);
      imem_ready   = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Parametrised instruction-fetch stage for the 3-stage pipeline. It owns the program counter, issues one instruction-memory read per cycle through a ready/request handshake, and buffers fetched words in a small prefetch queue. The queue decouples fetch from decode stalls. A redirect input (branch/jump resolved downstream) flushes the queue and restarts fetch at a new address.

## Interface
Parameters:
- ADDR_W, 8, PC / instruction-memory address width
- INSTR_W, 16, instruction word width
- DEPTH, 4, prefetch queue entries (≥2)
- RESET_PC, 0, PC value after reset

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- imem_req  out  1  read request; address valid on imem_addr
- imem_addr  out  ADDR_W  current PC
- imem_ready  in  1  memory accepts request and returns data this cycle
- imem_data  in  INSTR_W  instruction word, valid when imem_req & imem_ready
- redirect  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  new PC when redirect=1
- ir_valid  out  1  queue head holds a valid instruction
- ir_out  out  INSTR_W  queue head instruction; 0 (NOP) when ir_valid=0
- ir_pc  out  ADDR_W  address of ir_out; 0 when ir_valid=0
- decode_ready  in  1  decode consumes head this cycle when ir_valid=1

## Operation
- Fetch fire: imem_req & imem_ready. On fire, {PC, imem_data} is pushed into the queue and PC ← PC+1 (mod 2^ADDR_W; 2^ADDR_W−1 wraps to 0).
- Pop: ir_valid & decode_ready. Head advances.
- imem_req = !rst & !redirect & (count < DEPTH | pop). Same-cycle pop frees a slot, so a full queue still fetches when decode consumes. This is a deliberate combinational path from decode_ready to imem_req.
- imem_addr = PC at all times.
- Queue occupancy count has width $clog2(DEPTH+1). On push without pop, count+1. On pop without push, count−1. On both, count is unchanged. A push into a full queue cannot occur by construction; an assertion checks it.
- Redirect has priority over fetch and pop. Next cycle: count=0, PC=redirect_pc, ir_valid=0. The imem_req is suppressed in the redirect cycle, so no stale word is queued. A pop in the redirect cycle is discarded.
- Reset has priority over redirect. PC=RESET_PC, count=0, head/tail pointers=0.
- Reset values: ir_valid=0, ir_out=0, ir_pc=0, imem_req=0 while rst high, imem_addr=RESET_PC after the reset edge.

## Timing
- Fetch-to-decode latency is 1 cycle. A word fired at edge-cycle t is presented on ir_out in cycle t+1 if the queue was empty.
- Sustained throughput is 1 instruction/cycle with imem_ready=1 and decode_ready=1.
- After redirect in cycle t: the first fetch at redirect_pc is in cycle t+1 and appears on ir_out in cycle t+2.
- Stall: with decode_ready=0, the queue fills in DEPTH fetch cycles, then imem_req drops. When decode_ready returns, fetch resumes in the same cycle.
- imem_ready=0 holds PC. The queue drains normally.

## Structure
- Shared package fetch_pkg:
  - default ADDR_W/INSTR_W constants
  - NOP encoding (all zero)
  - a queue-entry struct {pc, instr}
- One sub-module, fetch_queue: a synchronous FIFO with parameters DEPTH and entry width, a push/pop/flush interface, and full/empty/count outputs. The top level holds only the PC register, request logic and redirect priority.

## Test plan
Memory model for all scenarios: imem_data = {addr, ~addr} (ADDR_W=8, INSTR_W=16), imem_ready=1 unless stated.
- Reset: rst high 2 cycles, RESET_PC=0 → ir_valid=0, ir_out=0, imem_req=0. First cycle after reset: imem_addr=0x00. Next cycle: ir_out=0x00FF, ir_pc=0x00.
- Streaming: decode_ready=1 for 300 cycles → ir_out increments 0x00FF, 0x01FE, …; PC wraps 0xFF→0x00, and ir_out goes 0xFF00 then 0x00FF with no gap.
- Stall/full: decode_ready=0 from PC=0x10 → 4 words queued (0x10–0x13), imem_req=0, imem_addr=0x14 held. Release → ir_out=0x10EF, then 0x11EE…, no loss or duplication.
- Redirect: redirect=1, redirect_pc=0x80 while queue holds 3 entries → next cycle ir_valid=0, imem_addr=0x80. The following cycle: ir_out=0x807F, ir_pc=0x80.
- Memory stall: imem_ready=0 for 3 cycles with queue holding 2 → queue drains to empty, ir_valid=0, PC unchanged. Fetch resumes at the held address.
- Simultaneous rst and redirect: rst=1, redirect=1, redirect_pc=0x40 → PC=RESET_PC, not 0x40; queue empty.
